incr_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares the single 16-bit NAND-level incrementer (`sixteen_bit_incremenator`) among several requesters. Each requester presents a 16-bit operand with a level request. The block grants one requester at a time, registers the operand, drives the incrementer, and returns the registered sum and carry-out over a valid/ready handshake. It sits between address/counter producers, such as PC and pointer logic, and the shared increment datapath.

---
 rtl/incr_arbiter_if.sv | 29 ++
 rtl/incr_arbiter.sv | 140 ++++++++++++++
 tb/tb_incr_arbiter.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/incr_arbiter_if.sv
// Requester/consumer bus for incr_arbiter.
//   req    : per-requester request level
//   data   : packed operands, requester i owns [16i+15:16i]
//   gnt    : one-cycle one-hot grant when the operand is captured
//   result : registered increment result, cout: registered carry-out
//   rid    : requester index that owns result
//   rvalid : response valid, rready: consumer accepts response
//   busy   : arbiter is mid-transaction
interface incr_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 3
);
  logic [NREQ-1:0]      req;
  logic [16*NREQ-1:0]   data;
  logic [NREQ-1:0]      gnt;
  logic [15:0]          result;
  logic                 cout;
  logic [IDW-1:0]       rid;
  logic                 rvalid;
  logic                 rready;
  logic                 busy;

  // requesters + consumer side
  modport master (output req, data, rready,
                  input  gnt, result, cout, rid, rvalid, busy);
  // arbiter side
  modport slave  (input  req, data, rready,
                  output gnt, result, cout, rid, rvalid, busy);
endinterface

// File: rtl/incr_arbiter.sv
// Round-robin arbiter that time-shares one 16-bit NAND-level incrementer.
// Ports:
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : incr_arbiter_if.slave (req/data in, gnt out, result/cout/rid
//             with rvalid/rready handshake out, busy out)
// Flow: IDLE picks a winner and captures its operand, CALC registers the
// incrementer output, RESP holds it until the consumer takes it.

// Ripple incrementer built from 2-input NANDs: sum = a + b + 1.
module sixteen_bit_incremenator (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] sum,
  output logic        cout
);
  logic [16:0] c;
  assign c[0] = 1'b1;

  for (genvar i = 0; i < 16; i++) begin : g_fa
    logic n1, n2, n3, x, n4, n5, n6;
    assign n1     = ~(a[i] & b[i]);
    assign n2     = ~(a[i] & n1);
    assign n3     = ~(b[i] & n1);
    assign x      = ~(n2 & n3);       // a ^ b
    assign n4     = ~(x & c[i]);
    assign n5     = ~(x & n4);
    assign n6     = ~(c[i] & n4);
    assign sum[i] = ~(n5 & n6);       // a ^ b ^ cin
    assign c[i+1] = ~(n1 & n4);       // ab | (a^b)cin
  end

  assign cout = c[16];
endmodule

module incr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 3
) (
  input logic            clk,
  input logic            reset_n,
  incr_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t          state, state_nxt;
  logic [IDW-1:0]  ptr, rid_q, winner;
  logic            found;
  logic [15:0]     opnd, sel_data, result_q, inc_sum;
  logic            cout_q, inc_cout, rvalid_q;
  logic [NREQ-1:0] gnt_q, win_oh;

  // (p + k) mod NREQ; p < NREQ and k <= NREQ so one conditional subtract
  // is enough.
  function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] p, input int k);
    logic [IDW:0] s;
    s = {1'b0, p} + (IDW+1)'(k);
    if (s >= (IDW+1)'(NREQ)) s = s - (IDW+1)'(NREQ);
    return s[IDW-1:0];
  endfunction

  sixteen_bit_incremenator u_inc (
    .a    (opnd),
    .b    (16'h0000),
    .sum  (inc_sum),
    .cout (inc_cout)
  );

  // Scan offsets 0..NREQ-1 from ptr; first requesting slot wins. The inner
  // loop keeps every req/data select at a constant index.
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    sel_data = '0;
    win_oh   = '0;
    for (int k = 0; k < NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!found && bus.req[i] && rr_idx(ptr, k) == IDW'(i)) begin
          found     = 1'b1;
          winner    = IDW'(i);
          sel_data  = bus.data[16*i +: 16];
          win_oh[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = CALC;
      CALC:    state_nxt = RESP;
      RESP:    if (rvalid_q && bus.rready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr      <= '0;
      opnd     <= '0;
      gnt_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      rid_q    <= '0;
      rvalid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (found) begin
          opnd  <= sel_data;
          gnt_q <= win_oh;
          rid_q <= winner;
        end
        CALC: begin
          gnt_q    <= '0;
          result_q <= inc_sum;
          cout_q   <= inc_cout;
          rvalid_q <= 1'b1;
        end
        RESP: if (rvalid_q && bus.rready) begin
          rvalid_q <= 1'b0;
          ptr      <= rr_idx(rid_q, 1);  // fairness pointer moves on completion only
        end
        default: ;
      endcase
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.result = result_q;
  assign bus.cout   = cout_q;
  assign bus.rid    = rid_q;
  assign bus.rvalid = rvalid_q;
  assign bus.busy   = (state != IDLE);
endmodule

// File: tb/tb_incr_arbiter.sv
module tb_incr_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 3;

  logic clk = 1'b0;
  logic reset_n;
  int   total = 0;
  int   bad   = 0;
  logic [19:0] exp_q[$];          // {rid, cout, result}
  logic [NREQ-1:0] prev_gnt = '0;

  always #5 clk = ~clk;

  incr_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  incr_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] id, input logic [15:0] opnd);
    logic [16:0] s;
    s = {1'b0, opnd} + 17'd1;
    exp_q.push_back({id, s[16], s[15:0]});
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_out"}, {bus.gnt, bus.result, bus.cout, bus.rid, bus.rvalid, bus.busy}, 32'h0);
  endtask

  // Scoreboard + protocol monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset_n) begin
      chk("gnt_rules",
          {$onehot0(bus.gnt), !(|bus.gnt && |prev_gnt), !(|bus.gnt && bus.rvalid)}, 3'b111);
      if (bus.rvalid && bus.rready) begin
        if (exp_q.size() == 0) chk("sb_unexpected", {bus.rid, bus.cout, bus.result}, 20'hxxxxx);
        else chk("sb_resp", {bus.rid, bus.cout, bus.result}, exp_q.pop_front());
      end
    end
    prev_gnt = bus.gnt;
  end

  initial begin
    reset_n = 1'b0;
    bus.req = '0; bus.data = '0; bus.rready = 1'b0;
    #3;
    chk_zero("reset");
    reset_n = 1'b1;
    tick(); tick();
    chk("idle_busy", bus.busy, 1'b0);

    // single request
    bus.req = 4'b0001; bus.data[15:0] = 16'h1234; bus.rready = 1'b1;
    push(3'd0, 16'h1234);
    tick();
    chk("single_gnt", {bus.gnt, bus.busy, bus.rvalid}, {4'b0001, 1'b1, 1'b0});
    bus.req = '0;
    tick();
    chk("single_resp", {bus.gnt, bus.rvalid, bus.rid, bus.cout, bus.result},
        {4'b0000, 1'b1, 3'd0, 1'b0, 16'h1235});
    tick();
    chk("single_done", {bus.rvalid, bus.busy}, 2'b00);

    // wrap-around: requester 2 with FFFF, then requester 3 with 00FF
    bus.req = 4'b0100; bus.data[47:32] = 16'hFFFF;
    push(3'd2, 16'hFFFF);
    tick();
    chk("wrap_gnt", bus.gnt, 4'b0100);
    bus.req = '0;
    tick();
    chk("wrap_resp", {bus.rid, bus.cout, bus.result}, {3'd2, 1'b1, 16'h0000});
    tick();
    bus.req = 4'b1000; bus.data[63:48] = 16'h00FF;
    push(3'd3, 16'h00FF);
    tick();
    chk("carry8_gnt", bus.gnt, 4'b1000);
    bus.req = '0;
    tick();
    chk("carry8_resp", {bus.rid, bus.cout, bus.result}, {3'd3, 1'b0, 16'h0100});
    tick();

    // fairness: all requesting, grants every 3 cycles in order 0,1,2,3,0,1
    for (int i = 0; i < NREQ; i++) bus.data[16*i +: 16] = 16'h1000 + 16'(i);
    for (int g = 0; g < 6; g++) push(3'(g % 4), 16'h1000 + 16'(g % 4));
    bus.req = 4'b1111;
    for (int g = 0; g < 6; g++) begin
      tick();
      chk("fair_gnt", bus.gnt, 4'b0001 << (g % 4));
      if (g == 5) bus.req = '0;
      tick();
      chk("fair_calc", {bus.gnt, bus.rvalid}, {4'b0000, 1'b1});
      tick();
      chk("fair_hs", {bus.gnt, bus.rvalid, bus.busy}, {4'b0000, 1'b0, 1'b0});
    end

    // back-pressure: requester 3 served, requester 1 waits behind it
    bus.rready = 1'b0;
    bus.req = 4'b1000; bus.data[63:48] = 16'hABCD; bus.data[31:16] = 16'h5555;
    push(3'd3, 16'hABCD);
    push(3'd1, 16'h5555);
    tick();
    chk("bp_gnt", bus.gnt, 4'b1000);
    bus.req = 4'b0010;
    tick();
    for (int c = 0; c < 5; c++) begin
      chk("bp_hold", {bus.gnt, bus.rvalid, bus.busy, bus.rid, bus.cout, bus.result},
          {4'b0000, 1'b1, 1'b1, 3'd3, 1'b0, 16'hABCE});
      tick();
    end
    bus.rready = 1'b1;
    tick();
    chk("bp_release", {bus.gnt, bus.rvalid}, {4'b0000, 1'b0});
    tick();
    chk("bp_next_gnt", bus.gnt, 4'b0010);
    bus.req = '0;
    tick();
    chk("bp_next_resp", {bus.rid, bus.result}, {3'd1, 16'h5556});
    tick();

    // reset while a response is held: outputs clear with no clock edge
    bus.rready = 1'b0;
    bus.req = 4'b0001; bus.data[15:0] = 16'hBEEF;
    tick();
    bus.req = '0;
    tick();
    chk("rst_pre", {bus.rvalid, bus.result}, {1'b1, 16'hBEF0});
    #2 reset_n = 1'b0;
    #1 chk_zero("async_rst");
    #1 reset_n = 1'b1;
    tick(); tick();
    chk("post_rst_busy", {bus.busy, bus.rvalid}, 2'b00);

    // move ptr off zero, then reset mid-CALC
    bus.rready = 1'b1;
    bus.req = 4'b0010; bus.data[31:16] = 16'h0010;
    push(3'd1, 16'h0010);
    tick();
    bus.req = '0;
    tick(); tick();
    bus.req = 4'b0100; bus.data[47:32] = 16'h0007;
    tick();
    chk("calc_rst_gnt", bus.gnt, 4'b0100);
    bus.req = '0;
    #2 reset_n = 1'b0;
    #1 chk_zero("calc_rst");
    tick();
    reset_n = 1'b1;
    tick(); tick(); tick();
    chk("calc_rst_norvalid", {bus.rvalid, bus.busy}, 2'b00);
    bus.req = 4'b1010; bus.data[31:16] = 16'h2222;
    push(3'd1, 16'h2222);
    tick();
    chk("ptr_reset_gnt", bus.gnt, 4'b0010);
    bus.req = '0;
    tick(); tick(); tick();

    chk("sb_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
